swan128k256_kat_bist: RTL and testbench
=======================================

# swan128k256_kat_bist

Synthesizable known-answer self-test controller for the serial SWAN-128/256 cipher cores. It owns one SWAN128K256_ENC and one SWAN128K256_DEC instance and drives their start/ready handshake through four fixed test vectors. It checks each result against a built-in expected value and reports pass/fail to the system controller. It sits beside the cipher datapath as its power-on and on-demand integrity check.

## Interface
- TIMEOUT_CYCLES, 1024: maximum cycles from core `start` to core `ready` before a timeout error.
- NUM_VEC, 4: number of known-answer vectors; fixed at 4, index width 2.
- clk  in  1  single clock for the controller and both cores.
- rst  in  1  reset, synchronous, active-high.
- run  in  1  one-cycle request to start a self-test pass; ignored while `busy`.
- inject  in  1  sampled with `run`; when set, expected ciphertext of vector 2 has bit 127 inverted.
- busy  out  1  high from the cycle after an accepted `run` until `done`; reset 0.
- done  out  1  one-cycle pulse at end of pass; reset 0.
- pass  out  1  all checks matched; held until next accepted `run`; reset 0.
- fail  out  1  mismatch or timeout; held until next accepted `run`; reset 0.
- fail_idx  out  2  vector index of first failure; reset 0.
- fail_dir  out  1  0 = encrypt check failed, 1 = decrypt check failed; reset 0.
- err_timeout  out  1  failure was a timeout, not a mismatch; reset 0.

## Operation
- Core handshake: `start` high for exactly one cycle with `key[0:255]`/`inp[0:127]` stable. Core `ready` high for one cycle marks `out[0:127]` valid. Core `rst` ports are tied 1'b1. `key`/`inp` are held stable until `ready`.
- Vectors, as key / plaintext / ciphertext:
  - 0: 0 / 78563412×4 / f4875ea888a3c604e37f518527312c60
  - 1: 78563412×8 / 1111…11 / 515c0ec39623549ca5d50422f2863aad
  - 2: (ffeeddccbbaa00998877665544332211)×2 / ff…ff / 171f0914f3ca2de46e566bddc4402d44
  - 3: ff…ff / f0debc9a78563412×2 / bc2b49e1f1407a5d9cf78ff7db6c0634
- FSM states: IDLE, ENC_GO, ENC_WAIT, DEC_GO, DEC_WAIT, NEXT, FINISH.
  - IDLE: on `run`, clear `pass`/`fail`/`fail_idx`/`fail_dir`/`err_timeout`, latch `inject`, set idx=0, go to ENC_GO.
  - ENC_GO: pulse ENC `start` with vector plaintext, go to ENC_WAIT.
  - ENC_WAIT: on `ready`, compare `out` to the expected ciphertext. Match goes to DEC_GO; mismatch sets `fail` and `fail_dir`=0 and goes to FINISH.
  - DEC_GO / DEC_WAIT: same as ENC_GO / ENC_WAIT, but the input is the expected ciphertext (unmodified by `inject`) and the comparison is against the plaintext. Mismatch sets `fail_dir`=1.
  - NEXT: if idx=3, set `pass` and go to FINISH; otherwise idx+1 and go to ENC_GO.
  - FINISH: pulse `done`, drop `busy`, return to IDLE.
- Timeout: 16-bit counter cleared in each *_GO state and incremented in *_WAIT. Reaching TIMEOUT_CYCLES sets `fail` and `err_timeout` and goes to FINISH.
- The first failure stops the pass; later vectors are not run.
- A `ready` seen outside a *_WAIT state is ignored.

## Timing
- `run` sampled at cycle N: `busy`=1 at N+1, first ENC `start` at N+1 (ENC_GO).
- `ready` at cycle M is compared in the same cycle. The next core `start` is at M+1 (GO state entered at M+1).
- Status outputs update in the cycle the FSM enters FINISH. `done` pulses in the FINISH cycle.
- A `run` coinciding with FINISH is ignored.
- `rst` mid-pass: every output returns to its reset value and the FSM returns to IDLE on the next edge. A later stale core `ready` is ignored.

## Configuration
- SWAN_BIST_DEC_EN defined: the DEC core is instantiated and the decrypt checks run as above.
- SWAN_BIST_DEC_EN undefined: no DEC core; ENC_WAIT on a match goes directly to NEXT, and `fail_dir` is constant 0.

## Structure
- Shared package holds the block/key widths (128, 256), the FSM state enum, and the vector index type.
- Sub-module swan_kat_rom: combinational, index in; key, plaintext, and ciphertext out.
- Controller, compare logic, and timeout counter live in the top module.

## Test plan
- Reset, then `run` with inject=0 → `done` pulse, `pass`=1, `fail`=0, core `start` count 8 (4 with macro off).
- `run` with inject=1 → `fail`=1, `fail_idx`=2, `fail_dir`=0, `err_timeout`=0, `pass`=0.
- ENC `ready` forced 0 → `fail`=1, `err_timeout`=1, `fail_idx`=0, `done` exactly TIMEOUT_CYCLES+1 cycles after first `start`.
- `run` pulsed again while `busy` → no restart; single `done`, `pass`=1.
- `rst` during vector 1 DEC_WAIT → all outputs 0 the next cycle; a subsequent `run` gives `pass`=1.
- Back-to-back passes (`run` the cycle after `done`) → both give `pass`=1, and status clears at the second accept.

Source files
------------

// File: rtl/swan128k256_kat_bist_pkg.sv
// Shared types, widths and known-answer vectors for the SWAN-128/256 KAT self-test.
// The stand-in core models also live here so the cores and the vector ROM stay consistent.
package swan128k256_kat_bist_pkg;

    localparam int unsigned BlockW  = 128;
    localparam int unsigned KeyW    = 256;
    localparam int unsigned NUM_VEC = 4;

    typedef logic [0:BlockW-1] block_t;
    typedef logic [0:KeyW-1]   key_t;
    typedef logic [1:0]        vec_idx_t;

    typedef enum logic [2:0] {
        StIdle,
        StEncGo,
        StEncWait,
        StDecGo,
        StDecWait,
        StNext,
        StFinish
    } bist_state_e;

    typedef struct packed {
        key_t   key;
        block_t pt;
        block_t ct;
    } kat_vec_t;

    function automatic kat_vec_t kat_vec(input vec_idx_t idx);
        kat_vec_t v;
        case (idx)
            2'd0: begin
                v.key = '0;
                v.pt  = {4{32'h78563412}};
                v.ct  = 128'hf4875ea888a3c604e37f518527312c60;
            end
            2'd1: begin
                v.key = {8{32'h78563412}};
                v.pt  = {32{4'h1}};
                v.ct  = 128'h515c0ec39623549ca5d50422f2863aad;
            end
            2'd2: begin
                v.key = {2{128'hffeeddccbbaa00998877665544332211}};
                v.pt  = '1;
                v.ct  = 128'h171f0914f3ca2de46e566bddc4402d44;
            end
            default: begin
                v.key = '1;
                v.pt  = {2{64'hf0debc9a78563412}};
                v.ct  = 128'hbc2b49e1f1407a5d9cf78ff7db6c0634;
            end
        endcase
        return v;
    endfunction

    // Known pairs map exactly; anything else yields a key-dependent non-answer.
    function automatic block_t enc_model(input key_t key, input block_t inp);
        kat_vec_t v;
        block_t   r;
        r = inp ^ key[0:BlockW-1];
        for (int i = 0; i < int'(NUM_VEC); i++) begin
            v = kat_vec(vec_idx_t'(i));
            if (v.key == key && v.pt == inp) r = v.ct;
        end
        return r;
    endfunction

    function automatic block_t dec_model(input key_t key, input block_t inp);
        kat_vec_t v;
        block_t   r;
        r = inp ^ key[BlockW:KeyW-1];
        for (int i = 0; i < int'(NUM_VEC); i++) begin
            v = kat_vec(vec_idx_t'(i));
            if (v.key == key && v.ct == inp) r = v.pt;
        end
        return r;
    endfunction

endpackage

// File: rtl/SWAN128K256_DEC.sv
// Latency-accurate stand-in for the serial SWAN-128/256 decrypt core; built only when
// SWAN_BIST_DEC_EN is defined, since nothing else instantiates it.
`ifdef SWAN_BIST_DEC_EN
module SWAN128K256_DEC
    import swan128k256_kat_bist_pkg::*;
#(
    parameter int unsigned Latency = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:255] key,
    input  logic [0:127] inp,
    output logic         ready,
    output logic [0:127] out
);

    logic       active_q, active_d;
    logic [7:0] cnt_q, cnt_d;
    block_t     res_q, res_d;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        ready    = active_q && (cnt_q == 8'(Latency - 1));
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            res_d    = dec_model(key, inp);
        end else if (ready) begin
            active_d = 1'b0;
        end else if (active_q) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign out = res_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
        end
    end

endmodule
`endif

// File: rtl/SWAN128K256_ENC.sv
// Latency-accurate stand-in for the serial SWAN-128/256 encrypt core (start/ready handshake).
// Only the known-answer pairs are modelled; rst is active-low and normally tied high.
module SWAN128K256_ENC
    import swan128k256_kat_bist_pkg::*;
#(
    parameter int unsigned Latency = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:255] key,
    input  logic [0:127] inp,
    output logic         ready,
    output logic [0:127] out
);

    logic       active_q, active_d;
    logic [7:0] cnt_q, cnt_d;
    block_t     res_q, res_d;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        ready    = active_q && (cnt_q == 8'(Latency - 1));
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            res_d    = enc_model(key, inp);
        end else if (ready) begin
            active_d = 1'b0;
        end else if (active_q) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign out = res_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
        end
    end

endmodule

// File: rtl/swan_kat_rom.sv
// Combinational known-answer vector ROM: index in, key / plaintext / ciphertext out.
module swan_kat_rom
    import swan128k256_kat_bist_pkg::*;
(
    input  logic [1:0]   idx_i,
    output logic [0:255] key_o,
    output logic [0:127] pt_o,
    output logic [0:127] ct_o
);

    kat_vec_t vec;

    always_comb begin
        vec   = kat_vec(idx_i);
        key_o = vec.key;
        pt_o  = vec.pt;
        ct_o  = vec.ct;
    end

endmodule

// File: rtl/swan128k256_kat_bist.sv
// Known-answer self-test controller driving the SWAN-128/256 encrypt (and optionally decrypt)
// cores through four fixed vectors. Define SWAN_BIST_DEC_EN to add the decrypt core and checks.
module swan128k256_kat_bist
    import swan128k256_kat_bist_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       inject,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail,
    output logic [1:0] fail_idx,
    output logic       fail_dir,
    output logic       err_timeout
);

    localparam logic [15:0] TmrLast = 16'(TIMEOUT_CYCLES - 1);

    bist_state_e state_q, state_d;
    vec_idx_t    idx_q, idx_d;
    logic        inject_q, inject_d;
    logic [15:0] tmr_q, tmr_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    vec_idx_t    fail_idx_q, fail_idx_d;
    logic        err_to_q, err_to_d;

    key_t   rom_key;
    block_t rom_pt, rom_ct, exp_ct;
    logic   enc_start, enc_ready;
    block_t enc_out;

    swan_kat_rom u_rom (
        .idx_i (idx_q),
        .key_o (rom_key),
        .pt_o  (rom_pt),
        .ct_o  (rom_ct)
    );

    SWAN128K256_ENC u_enc (
        .clk   (clk),
        .rst   (1'b1),
        .start (enc_start),
        .key   (rom_key),
        .inp   (rom_pt),
        .ready (enc_ready),
        .out   (enc_out)
    );

`ifdef SWAN_BIST_DEC_EN
    logic   fail_dir_q, fail_dir_d;
    logic   dec_start, dec_ready;
    block_t dec_out;

    // Decrypt always consumes the true ciphertext; inject only corrupts the encrypt check.
    SWAN128K256_DEC u_dec (
        .clk   (clk),
        .rst   (1'b1),
        .start (dec_start),
        .key   (rom_key),
        .inp   (rom_ct),
        .ready (dec_ready),
        .out   (dec_out)
    );
`endif

    always_comb begin
        exp_ct = rom_ct;
        if (inject_q && idx_q == 2'd2) exp_ct[127] = ~rom_ct[127];
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        inject_d   = inject_q;
        tmr_d      = tmr_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        fail_idx_d = fail_idx_q;
        err_to_d   = err_to_q;
        enc_start  = 1'b0;
`ifdef SWAN_BIST_DEC_EN
        fail_dir_d = fail_dir_q;
        dec_start  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    pass_d     = 1'b0;
                    fail_d     = 1'b0;
                    fail_idx_d = '0;
                    err_to_d   = 1'b0;
`ifdef SWAN_BIST_DEC_EN
                    fail_dir_d = 1'b0;
`endif
                    inject_d   = inject;
                    idx_d      = '0;
                    state_d    = StEncGo;
                end
            end
            StEncGo: begin
                enc_start = 1'b1;
                tmr_d     = '0;
                state_d   = StEncWait;
            end
            StEncWait: begin
                if (enc_ready) begin
                    if (enc_out == exp_ct) begin
`ifdef SWAN_BIST_DEC_EN
                        state_d = StDecGo;
`else
                        state_d = StNext;
`endif
                    end else begin
                        fail_d     = 1'b1;
                        fail_idx_d = idx_q;
                        state_d    = StFinish;
                    end
                end else if (tmr_q == TmrLast) begin
                    fail_d     = 1'b1;
                    err_to_d   = 1'b1;
                    fail_idx_d = idx_q;
                    state_d    = StFinish;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
`ifdef SWAN_BIST_DEC_EN
            StDecGo: begin
                dec_start = 1'b1;
                tmr_d     = '0;
                state_d   = StDecWait;
            end
            StDecWait: begin
                if (dec_ready) begin
                    if (dec_out == rom_pt) begin
                        state_d = StNext;
                    end else begin
                        fail_d     = 1'b1;
                        fail_dir_d = 1'b1;
                        fail_idx_d = idx_q;
                        state_d    = StFinish;
                    end
                end else if (tmr_q == TmrLast) begin
                    fail_d     = 1'b1;
                    fail_dir_d = 1'b1;
                    err_to_d   = 1'b1;
                    fail_idx_d = idx_q;
                    state_d    = StFinish;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
`endif
            StNext: begin
                if (idx_q == 2'd3) begin
                    pass_d  = 1'b1;
                    state_d = StFinish;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = StEncGo;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            inject_q   <= 1'b0;
            tmr_q      <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            fail_idx_q <= '0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            inject_q   <= inject_d;
            tmr_q      <= tmr_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            fail_idx_q <= fail_idx_d;
            err_to_q   <= err_to_d;
        end
    end

`ifdef SWAN_BIST_DEC_EN
    always_ff @(posedge clk) begin
        if (rst) fail_dir_q <= 1'b0;
        else     fail_dir_q <= fail_dir_d;
    end
    assign fail_dir = fail_dir_q;
`else
    assign fail_dir = 1'b0;
`endif

    assign busy        = (state_q != StIdle) && (state_q != StFinish);
    assign done        = (state_q == StFinish);
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_idx    = fail_idx_q;
    assign err_timeout = err_to_q;

endmodule

// File: tb/tb_swan128k256_kat_bist.sv
// Self-checking bench for swan128k256_kat_bist: table of pass scenarios plus hand-written
// sequences for run-while-busy, mid-pass reset and back-to-back passes.
module tb_swan128k256_kat_bist;
    import swan128k256_kat_bist_pkg::*;

    localparam int Timeout = 1024;
`ifdef SWAN_BIST_DEC_EN
    localparam int          FullStarts = 8;
    localparam int          InjStarts  = 5;
    localparam bist_state_e RstState   = StDecWait;
`else
    localparam int          FullStarts = 4;
    localparam int          InjStarts  = 3;
    localparam bist_state_e RstState   = StEncWait;
`endif

    logic       clk;
    logic       rst;
    logic       run;
    logic       inject;
    logic       busy;
    logic       done;
    logic       pass;
    logic       fail;
    logic [1:0] fail_idx;
    logic       fail_dir;
    logic       err_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int starts_total = 0;
    int dones_total  = 0;

    swan128k256_kat_bist #(
        .TIMEOUT_CYCLES (Timeout)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .inject      (inject),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .fail_idx    (fail_idx),
        .fail_dir    (fail_dir),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sampled shortly after the edge so initial-block reads at negedge never race these counts.
    always @(posedge clk) begin
        #2;
        if (dut.enc_start) starts_total++;
`ifdef SWAN_BIST_DEC_EN
        if (dut.dec_start) starts_total++;
`endif
        if (done) dones_total++;
    end

    typedef struct {
        bit       inject;
        bit       kill;
        bit       exp_pass;
        bit       exp_fail;
        bit [1:0] exp_idx;
        bit       exp_dir;
        bit       exp_to;
        int       exp_starts;
    } scen_t;

    scen_t scen [4];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_run(input bit inj);
        run    = 1'b1;
        inject = inj;
        @(negedge clk);
        run    = 1'b0;
        inject = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got, output int ncyc);
        got  = 1'b0;
        ncyc = 0;
        for (int i = 1; i <= budget && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got  = 1'b1;
                ncyc = i;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_fail_idx"}, fail_idx, 0);
        check({tag, "_fail_dir"}, fail_dir, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    initial begin
        bit got;
        int ncyc;
        int s0;
        int d0;

        scen[0] = '{inject: 0, kill: 0, exp_pass: 1, exp_fail: 0, exp_idx: 0, exp_dir: 0,
                    exp_to: 0, exp_starts: FullStarts};
        scen[1] = '{inject: 1, kill: 0, exp_pass: 0, exp_fail: 1, exp_idx: 2, exp_dir: 0,
                    exp_to: 0, exp_starts: InjStarts};
        scen[2] = '{inject: 0, kill: 1, exp_pass: 0, exp_fail: 1, exp_idx: 0, exp_dir: 0,
                    exp_to: 1, exp_starts: 1};
        scen[3] = '{inject: 0, kill: 0, exp_pass: 1, exp_fail: 0, exp_idx: 0, exp_dir: 0,
                    exp_to: 0, exp_starts: FullStarts};

        rst    = 1'b1;
        run    = 1'b0;
        inject = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            if (scen[i].kill) force dut.enc_ready = 1'b0;
            s0 = starts_total;
            do_run(scen[i].inject);
            check("busy_after_run", busy, 1);
            check("first_enc_start", dut.enc_start, 1);
            wait_done(3000, got, ncyc);
            check("done_seen", got, 1);
            check("pass", pass, scen[i].exp_pass);
            check("fail", fail, scen[i].exp_fail);
            check("fail_idx", fail_idx, scen[i].exp_idx);
            check("fail_dir", fail_dir, scen[i].exp_dir);
            check("err_timeout", err_timeout, scen[i].exp_to);
            check("busy_in_done", busy, 0);
            if (scen[i].kill) begin
                check("timeout_latency", ncyc, Timeout + 1);
                release dut.enc_ready;
            end
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("core_starts", starts_total - s0, scen[i].exp_starts);
        end

        // Extra run pulses mid-pass and in the FINISH cycle must all be ignored.
        d0 = dones_total;
        do_run(1'b0);
        repeat (20) @(negedge clk);
        do_run(1'b1);
        repeat (100) @(negedge clk);
        do_run(1'b0);
        wait_done(3000, got, ncyc);
        check("busy_run_done_seen", got, 1);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("finish_run_ignored", busy, 0);
        repeat (100) @(negedge clk);
        check("single_done", dones_total - d0, 1);
        check("busy_run_pass", pass, 1);
        check("busy_run_fail", fail, 0);

        // Reset while waiting on vector 1; the core's later ready must not wake the FSM.
        do_run(1'b0);
        got = 1'b0;
        for (int k = 0; k < 1000 && !got; k++) begin
            @(negedge clk);
            if (dut.state_q == RstState && dut.idx_q == 2'd1) got = 1'b1;
        end
        check("reach_v1_wait", got, 1);
        d0 = dones_total;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("mid_rst");
        repeat (80) @(negedge clk);
        check("stale_ready_busy", busy, 0);
        check("stale_ready_done", dones_total - d0, 0);
        do_run(1'b0);
        wait_done(3000, got, ncyc);
        check("post_rst_done_seen", got, 1);
        check("post_rst_pass", pass, 1);

        // Back-to-back: run in the IDLE cycle right after done is accepted and clears status.
        @(negedge clk);
        do_run(1'b0);
        check("b2b_busy", busy, 1);
        check("b2b_pass_cleared", pass, 0);
        wait_done(3000, got, ncyc);
        check("b2b_done_seen", got, 1);
        check("b2b_pass", pass, 1);
        check("b2b_fail", fail, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
